// File: rtl/sram_arbiter.sv
// SRAM sequencer/arbiter sharing the external 128 KiB SRAM between CPU and VPU fetch.
// Optional feature macro: SRAM_ARB_PAGE_EN enables the $C000-$DFFF paged window.
module sram_arbiter #(
  parameter int unsigned WAIT_STATES   = 1,
  parameter int unsigned VPU_BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_ad,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  cpu_di,
  output logic        cpu_hold,
  input  logic [3:0]  page,
  input  logic        vpu_req,
  input  logic [15:0] vpu_ad,
  output logic        vpu_ack,
  output logic [7:0]  vpu_data,
  output logic [16:0] ext_ad,
  input  logic [7:0]  ext_dq_i,
  output logic [7:0]  ext_dq_o,
  output logic        ext_dq_oe,
  output logic        ext_ce_n,
  output logic        ext_oe_n,
  output logic        ext_we_n
);

  localparam int unsigned AW = 17;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;
  typedef enum logic {OWN_VPU = 1'b0, OWN_CPU = 1'b1} own_t;

  state_t          r_state;
  own_t            r_own;
  logic [2:0]      r_wcnt;
  logic [3:0]      r_bcnt;
  logic            r_rw;
  logic            r_keep;
  logic [AW-1:0]   r_ext_ad;
  logic [7:0]      r_ext_dq_o;
  logic            r_ce_n;
  logic            r_oe_n;
  logic            r_we_n;
  logic            r_dq_oe;
  logic [7:0]      r_cpu_di;
  logic [7:0]      r_vpu_data;
  logic            r_vpu_ack;

  logic            w_vpu_win;
  logic            w_cpu_win;
  logic [AW-1:0]   w_cpu_ext_ad;

  // VPU keeps winning until its burst allowance runs out while the CPU waits
  assign w_vpu_win = vpu_req && (!cpu_req || (r_bcnt < 4'(VPU_BURST_MAX)));
  assign w_cpu_win = cpu_req && !w_vpu_win;

`ifdef SRAM_ARB_PAGE_EN
  assign w_cpu_ext_ad = (page[3] && (cpu_ad[15:13] == 3'b110)) ?
                        {1'b1, page[2:0], cpu_ad[12:0]} : {1'b0, cpu_ad};
`else
  logic w_unused_page;
  assign w_unused_page = ^page;
  assign w_cpu_ext_ad  = {1'b0, cpu_ad};
`endif

  assign cpu_hold  = cpu_req && !((r_state == S_DONE) && (r_own == OWN_CPU));
  assign cpu_di    = r_cpu_di;
  assign vpu_ack   = r_vpu_ack;
  assign vpu_data  = r_vpu_data;
  assign ext_ad    = r_ext_ad;
  assign ext_dq_o  = r_ext_dq_o;
  assign ext_dq_oe = r_dq_oe;
  assign ext_ce_n  = r_ce_n;
  assign ext_oe_n  = r_oe_n;
  assign ext_we_n  = r_we_n;

  // Sequencer; strobes are registered from the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_own      <= OWN_VPU;
      r_wcnt     <= 3'd0;
      r_bcnt     <= 4'd0;
      r_rw       <= 1'b1;
      r_keep     <= 1'b0;
      r_ext_ad   <= '0;
      r_ext_dq_o <= 8'h00;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_dq_oe    <= 1'b0;
      r_cpu_di   <= 8'hFF;
      r_vpu_data <= 8'h00;
      r_vpu_ack  <= 1'b0;
    end else begin
      if (!cpu_req) r_bcnt <= 4'd0;
      case (r_state)
        S_IDLE: begin
          if (w_vpu_win) begin
            r_state  <= S_SETUP;
            r_own    <= OWN_VPU;
            r_rw     <= 1'b1;
            r_ext_ad <= {1'b0, vpu_ad};
            r_ce_n   <= 1'b0;
            if (cpu_req) r_bcnt <= r_bcnt + 4'd1;
          end else if (w_cpu_win) begin
            r_state    <= S_SETUP;
            r_own      <= OWN_CPU;
            r_rw       <= cpu_rw;
            r_ext_ad   <= w_cpu_ext_ad;
            r_ext_dq_o <= cpu_do;
            r_ce_n     <= 1'b0;
            r_dq_oe    <= !cpu_rw;
            r_bcnt     <= 4'd0;
            r_keep     <= 1'b1;
          end
        end
        S_SETUP: begin
          r_state <= S_ACCESS;
          r_wcnt  <= 3'(WAIT_STATES);
          r_oe_n  <= !r_rw;
          r_we_n  <= r_rw;
          r_dq_oe <= !r_rw;
          if (!cpu_req) r_keep <= 1'b0;
        end
        S_ACCESS: begin
          if (!cpu_req) r_keep <= 1'b0;
          if (r_wcnt == 3'd0) begin
            r_state   <= S_DONE;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_vpu_ack <= (r_own == OWN_VPU);
            if (r_own == OWN_VPU) begin
              r_vpu_data <= ext_dq_i;
            end else if (r_rw && r_keep && cpu_req) begin
              r_cpu_di <= ext_dq_i;
            end
          end else begin
            r_wcnt <= r_wcnt - 3'd1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_dq_oe   <= 1'b0;
          r_vpu_ack <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: transaction-level model plus directed scenarios.
module tb_sram_arbiter;

  localparam int WS = 1;
  localparam int BM = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_rw, vpu_req;
  logic [15:0] cpu_ad, vpu_ad;
  logic [7:0]  cpu_do, ext_dq_i;
  logic [3:0]  page;
  logic [7:0]  cpu_di, vpu_data, ext_dq_o;
  logic        cpu_hold, vpu_ack, ext_dq_oe, ext_ce_n, ext_oe_n, ext_we_n;
  logic [16:0] ext_ad;

  sram_arbiter #(.WAIT_STATES(WS), .VPU_BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_ad(cpu_ad), .cpu_do(cpu_do),
    .cpu_di(cpu_di), .cpu_hold(cpu_hold), .page(page),
    .vpu_req(vpu_req), .vpu_ad(vpu_ad), .vpu_ack(vpu_ack), .vpu_data(vpu_data),
    .ext_ad(ext_ad), .ext_dq_i(ext_dq_i), .ext_dq_o(ext_dq_o), .ext_dq_oe(ext_dq_oe),
    .ext_ce_n(ext_ce_n), .ext_oe_n(ext_oe_n), .ext_we_n(ext_we_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Transaction model: m_k counts cycles since grant (1 = setup, last = done)
  logic        m_busy, m_own_cpu, m_rw, m_keep;
  int          m_k, m_bcnt;
  logic [16:0] m_ext_ad;
  logic [7:0]  m_dq_o, m_cpu_di, m_vpu_data;

  function automatic logic [16:0] map_cpu(input logic [15:0] a, input logic [3:0] p);
`ifdef SRAM_ARB_PAGE_EN
    if (p[3] && a[15:13] == 3'b110) return {1'b1, p[2:0], a[12:0]};
`endif
    return {1'b0, a} | 17'(p & 4'h0);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_own_cpu <= 1'b0; m_rw <= 1'b1; m_keep <= 1'b0;
      m_k <= 0; m_bcnt <= 0; m_ext_ad <= '0; m_dq_o <= 8'h00;
      m_cpu_di <= 8'hFF; m_vpu_data <= 8'h00;
    end else if (!m_busy) begin
      if (vpu_req && (!cpu_req || m_bcnt < BM)) begin
        m_busy <= 1'b1; m_k <= 1; m_own_cpu <= 1'b0; m_rw <= 1'b1;
        m_ext_ad <= {1'b0, vpu_ad};
        m_bcnt <= cpu_req ? m_bcnt + 1 : 0;
      end else if (cpu_req) begin
        m_busy <= 1'b1; m_k <= 1; m_own_cpu <= 1'b1; m_rw <= cpu_rw;
        m_ext_ad <= map_cpu(cpu_ad, page); m_dq_o <= cpu_do;
        m_bcnt <= 0; m_keep <= 1'b1;
      end else begin
        m_bcnt <= 0;
      end
    end else begin
      if (!cpu_req) m_bcnt <= 0;
      if (m_k <= WS + 2 && !cpu_req) m_keep <= 1'b0;
      if (m_k == WS + 2) begin
        if (!m_own_cpu) m_vpu_data <= ext_dq_i;
        else if (m_rw && m_keep && cpu_req) m_cpu_di <= ext_dq_i;
      end
      if (m_k == WS + 3) m_busy <= 1'b0;
      else m_k <= m_k + 1;
    end
  end

  logic e_act, e_acc, e_done;
  assign e_act  = m_busy && (m_k <= WS + 2);
  assign e_acc  = m_busy && (m_k >= 2) && (m_k <= WS + 2);
  assign e_done = m_busy && (m_k == WS + 3);

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ext_ce_n", 32'(ext_ce_n), 32'(!e_act));
      chk("ext_oe_n", 32'(ext_oe_n), 32'(!(e_acc && m_rw)));
      chk("ext_we_n", 32'(ext_we_n), 32'(!(e_acc && !m_rw)));
      chk("ext_dq_oe", 32'(ext_dq_oe), 32'(m_busy && !m_rw));
      chk("ext_ad", 32'(ext_ad), 32'(m_ext_ad));
      chk("ext_dq_o", 32'(ext_dq_o), 32'(m_dq_o));
      chk("vpu_ack", 32'(vpu_ack), 32'(e_done && !m_own_cpu));
      chk("cpu_hold", 32'(cpu_hold), 32'(cpu_req && !(e_done && m_own_cpu)));
      chk("cpu_di", 32'(cpu_di), 32'(m_cpu_di));
      chk("vpu_data", 32'(vpu_data), 32'(m_vpu_data));
      chk("we_oe_excl", 32'(ext_oe_n | ext_we_n), 32'd1);
      chk("dq_oe_vs_oe", 32'(ext_dq_oe && !ext_oe_n), 32'd0);
    end
  end

  int          n_oe, n_we, n_hold, n_ack, n_ce, n_ev, n_v;
  logic        ok, oe_done;
  logic [16:0] ad_seen;
  logic [7:0]  dq_done;
  int          ev[10];
  int          ack_cyc[3];

  task automatic cpu_access(input logic rw, input logic [15:0] ad, input logic [7:0] d,
                            output int o_oe, output int o_we, output int o_hold,
                            output logic [16:0] o_ad, output logic o_oe_done,
                            output logic [7:0] o_dq, output logic o_ok);
    @(posedge clk); #2;
    cpu_req = 1'b1; cpu_rw = rw; cpu_ad = ad; cpu_do = d;
    o_oe = 0; o_we = 0; o_hold = 0; o_ad = '0; o_oe_done = 1'b0; o_dq = '0; o_ok = 1'b0;
    for (int i = 0; i < 20 && !o_ok; i++) begin
      @(negedge clk);
      if (!ext_oe_n) o_oe++;
      if (!ext_we_n) o_we++;
      if (!ext_ce_n) begin
        o_ad = ext_ad;
        if (cpu_hold) o_hold++;
      end
      if (!cpu_hold) begin
        o_ok = 1'b1; o_oe_done = ext_dq_oe; o_dq = ext_dq_o;
      end
    end
    #1; cpu_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_rw = 1'b1; cpu_ad = '0; cpu_do = '0;
    vpu_req = 1'b0; vpu_ad = '0; page = 4'b0000; ext_dq_i = 8'h00;
    repeat (2) @(posedge clk);
    #2; cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_ce_n", 32'(ext_ce_n), 32'd1);
    chk("rst_cpu_di", 32'(cpu_di), 32'hFF);
    chk("rst_ext_ad", 32'(ext_ad), 32'd0);
    @(posedge clk); #2; rst = 1'b1;

    // CPU read $1234
    ext_dq_i = 8'hA5;
    cpu_access(1'b1, 16'h1234, 8'h00, n_oe, n_we, n_hold, ad_seen, oe_done, dq_done, ok);
    chk("rd_done", 32'(ok), 32'd1);
    chk("rd_ext_ad", 32'(ad_seen), 32'h01234);
    chk("rd_oe_cycles", 32'(n_oe), 32'd2);
    chk("rd_hold_cycles", 32'(n_hold), 32'd3);
    chk("rd_cpu_di", 32'(cpu_di), 32'hA5);

    // Paged write $C010
    page = 4'b1101;
    cpu_access(1'b0, 16'hC010, 8'h3C, n_oe, n_we, n_hold, ad_seen, oe_done, dq_done, ok);
    chk("wr_done", 32'(ok), 32'd1);
`ifdef SRAM_ARB_PAGE_EN
    chk("wr_ext_ad", 32'(ad_seen), 32'h1A010);
`else
    chk("wr_ext_ad", 32'(ad_seen), 32'h0C010);
`endif
    chk("wr_we_cycles", 32'(n_we), 32'd2);
    chk("wr_oe_cycles", 32'(n_oe), 32'd0);
    chk("wr_dq_oe_done", 32'(oe_done), 32'd1);
    chk("wr_dq_o_done", 32'(dq_done), 32'h3C);

    // Window disabled: flat mapping in any build
    page = 4'b0101;
    cpu_access(1'b0, 16'hC010, 8'h96, n_oe, n_we, n_hold, ad_seen, oe_done, dq_done, ok);
    chk("wr_nowin_ext_ad", 32'(ad_seen), 32'h0C010);
    page = 4'b0000;

    // Both requesting: burst limit then one CPU grant
    @(posedge clk); #2;
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_ad = 16'h0100;
    vpu_req = 1'b1; vpu_ad = 16'h4000; ext_dq_i = 8'h11;
    n_ev = 0;
    for (int i = 0; i < 200 && n_ev < 10; i++) begin
      @(negedge clk);
      if (vpu_ack) begin ev[n_ev] = 0; n_ev++; end
      else if (cpu_req && !cpu_hold) begin ev[n_ev] = 1; n_ev++; end
    end
    #1; cpu_req = 1'b0; vpu_req = 1'b0;
    chk("burst_events", 32'(n_ev), 32'd10);
    n_v = 0;
    for (int i = 0; i < 8; i++) if (ev[i] == 0) n_v++;
    chk("burst_vpu_first8", 32'(n_v), 32'd8);
    chk("burst_cpu_9th", 32'(ev[8]), 32'd1);
    chk("burst_vpu_10th", 32'(ev[9]), 32'd0);

    // VPU alone
    @(posedge clk); #2;
    vpu_req = 1'b1; vpu_ad = 16'h4000; ext_dq_i = 8'h5A;
    n_ack = 0; n_hold = 0; ad_seen = '0;
    for (int i = 0; i < 40 && n_ack < 3; i++) begin
      @(negedge clk);
      if (cpu_hold) n_hold++;
      if (!ext_ce_n) ad_seen = ext_ad;
      if (vpu_ack) begin ack_cyc[n_ack] = i; n_ack++; end
    end
    #1; vpu_req = 1'b0;
    chk("vpu_acks", 32'(n_ack), 32'd3);
    chk("vpu_spacing1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd5);
    chk("vpu_spacing2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd5);
    chk("vpu_no_hold", 32'(n_hold), 32'd0);
    chk("vpu_ext_ad", 32'(ad_seen), 32'h04000);
    chk("vpu_data_lit", 32'(vpu_data), 32'h5A);

    // Reset during write ACCESS
    @(posedge clk); #2;
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_ad = 16'h0200; cpu_do = 8'h77; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (!ext_we_n) ok = 1'b1;
    end
    chk("rst_reached_access", 32'(ok), 32'd1);
    #1; rst = 1'b0; cpu_req = 1'b0;
    #1;
    chk("rst_async_we_n", 32'(ext_we_n), 32'd1);
    chk("rst_async_dq_oe", 32'(ext_dq_oe), 32'd0);
    chk("rst_async_ce_n", 32'(ext_ce_n), 32'd1);
    @(posedge clk); #2; rst = 1'b1;
    n_ack = 0; n_ce = 0;
    repeat (8) begin
      @(negedge clk);
      if (vpu_ack) n_ack++;
      if (!ext_ce_n) n_ce++;
    end
    chk("post_rst_no_ack", 32'(n_ack), 32'd0);
    chk("post_rst_idle", 32'(n_ce), 32'd0);

    // CPU request dropped in SETUP, then a VPU fetch
    @(posedge clk); #2;
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_ad = 16'h0300; ext_dq_i = 8'hC3; ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (!ext_ce_n) ok = 1'b1;
    end
    chk("drop_setup_seen", 32'(ok), 32'd1);
    #1; cpu_req = 1'b0; vpu_req = 1'b1; vpu_ad = 16'h4001;
    n_hold = 0; n_ack = 0; n_ce = 0;
    for (int i = 0; i < 30 && n_ack < 1; i++) begin
      @(negedge clk);
      if (cpu_hold) n_hold++;
      if (!ext_ce_n) n_ce++;
      if (vpu_ack) n_ack++;
    end
    #1; vpu_req = 1'b0;
    chk("drop_vpu_ack", 32'(n_ack), 32'd1);
    chk("drop_no_hold", 32'(n_hold), 32'd0);
    chk("drop_ce_cycles", 32'(n_ce), 32'd5);
    chk("drop_cpu_di_kept", 32'(cpu_di), 32'hFF);
    chk("drop_vpu_data", 32'(vpu_data), 32'hC3);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequencer and arbiter for the external 128 KiB SRAM, shared between the CPU bus (external-decode path) and the VPU video fetch port. It owns all SRAM strobes and the 17-bit external address, applies the $C000–$DFFF paged window, inserts configurable wait states, and stalls the CPU while the SRAM is busy on its behalf. It sits between the top-level address decoder and the SRAM pins, replacing direct strobe generation from the system clock phase.

## Interface
- WAIT_STATES, 1: extra ACCESS cycles per transaction (0–7).
- VPU_BURST_MAX, 8: maximum consecutive VPU grants while a CPU request is pending (1–15).

- clk  in  1  system clock (sys_clk).
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU external access (en_ext && vma).
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_ad  in  16  CPU address.
- cpu_do  in  8  CPU write data.
- cpu_di  out  8  registered read data to the CPU mux.
- cpu_hold  out  1  CPU stall; freezes cpu_clk.
- page  in  4  pagesel output; bit 3 enables the window, [2:0] selects the bank.
- vpu_req  in  1  VPU fetch request (vramcs && !en_bram).
- vpu_ad  in  16  VPU fetch address.
- vpu_ack  out  1  one-cycle pulse: vpu_data valid.
- vpu_data  out  8  registered fetch data.
- ext_ad  out  17  SRAM address.
- ext_dq_i  in  8  SRAM data in.
- ext_dq_o  out  8  SRAM data out.
- ext_dq_oe  out  1  pad output enable for ext_dq_o.
- ext_ce_n, ext_oe_n, ext_we_n  out  1 each  SRAM strobes, active low.

## Operation
- States: IDLE, SETUP, ACCESS, DONE. Owner register `own` (CPU/VPU); wait counter `wcnt`, 3 bits; burst counter `bcnt`, 4 bits.
- IDLE: with no request, stay in IDLE. Otherwise grant, latch address/rw/data, and go to SETUP.
  - Grant rule: VPU wins if vpu_req && (!cpu_req || bcnt < VPU_BURST_MAX). Else CPU wins if cpu_req.
- bcnt updates at grant:
  - +1 on a VPU grant while cpu_req = 1.
  - Cleared on a CPU grant, or whenever cpu_req = 0.
- Address mapping:
  - VPU: ext_ad = {1'b0, vpu_ad}.
  - CPU: if page[3] && cpu_ad[15:13] == 3'b110, ext_ad = {1'b1, page[2:0], cpu_ad[12:0]}; else {1'b0, cpu_ad}.
- SETUP: ext_ce_n = 0, address stable. For writes, ext_dq_oe = 1 with latched data. Load wcnt = WAIT_STATES. Go to ACCESS.
- ACCESS: ext_ce_n = 0. Read: ext_oe_n = 0. Write: ext_we_n = 0, ext_dq_oe = 1. Decrement wcnt; leave for DONE when wcnt == 0.
  - Read data is captured from ext_dq_i on the clock edge leaving ACCESS.
- DONE: strobes high, ext_ce_n = 1. Write data is still driven, giving one hold cycle.
  - VPU owner: vpu_ack = 1.
  - CPU owner: cpu_hold = 0 this cycle, so the CPU completes the cycle.
  - Go to IDLE.
- cpu_hold = cpu_req && !(state == DONE && own == CPU). Combinational.
- cpu_req dropped mid-transaction: the transaction still completes and its result is discarded. A CPU write still writes.
- ext_ad and latched data hold their last value in IDLE.

## Timing
- Grant edge to DONE entry: WAIT_STATES + 2 cycles. Transaction occupancy: WAIT_STATES + 3 cycles.
- Back-to-back: DONE → IDLE → SETUP, so minimum spacing is WAIT_STATES + 4 cycles.
- Reset values (asynchronous, immediate, also mid-transaction):
  - state IDLE, own VPU, bcnt 0, wcnt 0.
  - ext_ce_n = ext_oe_n = ext_we_n = 1, ext_dq_oe = 0.
  - ext_ad = 0, ext_dq_o = 0.
  - cpu_di = 8'hFF, vpu_data = 0, vpu_ack = 0.
  - cpu_hold follows its equation (= cpu_req in IDLE).
- ext_we_n and ext_oe_n are never low together. ext_dq_oe is never 1 while ext_oe_n = 0.
- Simultaneous requests on the same edge follow the grant rule. A request arriving during SETUP/ACCESS/DONE waits for IDLE.

## Configuration
- SRAM_ARB_PAGE_EN defined: page mapping active as above.
- Not defined: page is ignored, and CPU accesses map to {1'b0, cpu_ad}.

## Test plan
- CPU read $1234, WAIT_STATES = 1, ext_dq_i = 8'hA5 → ext_ad = 17'h01234, ext_oe_n low for 2 cycles, cpu_hold high for 3 cycles then low for 1, cpu_di = 8'hA5.
- page = 4'b1101, CPU write $C010 = 8'h3C → ext_ad = 17'h1A010, ext_we_n low 2 cycles, ext_dq_o = 8'h3C with ext_dq_oe held through DONE. Repeat without SRAM_ARB_PAGE_EN → ext_ad = 17'h0C010.
- cpu_req and vpu_req held high, VPU_BURST_MAX = 8 → exactly 8 vpu_ack pulses, then 1 CPU grant, then VPU again.
- vpu_req alone, vpu_ad = $4000 → vpu_ack pulses every WAIT_STATES + 4 cycles, and cpu_hold stays 0.
- rst asserted during ACCESS of a write → ext_we_n = 1 and ext_dq_oe = 0 immediately. After release, state is IDLE and no ack occurs.
- cpu_req dropped in SETUP → transaction finishes through DONE, cpu_hold = 0, and the next VPU request is granted normally.
